// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte-addressed loads/stores onto a word-indexed memory.
// Sub-word stores use a two-cycle read-modify-write that stalls the pipeline one cycle.
module load_store_unit #(
  parameter int unsigned WORD_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        fault,
  output logic        mm_memRead,
  output logic        mm_memWrite,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_writeData,
  input  logic [31:0] mm_data
);

  localparam int unsigned PadBits = 32 - WORD_ADDR_BITS;

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               merge_q, merge_d;
  logic [WORD_ADDR_BITS-1:0] waddr_q, waddr_d;

  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [31:0]               merged;
  logic                      misalign, bad_load, bad_store, req_fault;
  logic                      unused_addr;

  // Upper address bits alias onto the implemented word range.
  assign word_idx    = addr[WORD_ADDR_BITS+1:2];
  assign unused_addr = ^addr[31:WORD_ADDR_BITS+2];

  assign ld_byte = mm_data[{addr[1:0], 3'b000} +: 8];
  assign ld_half = addr[1] ? mm_data[31:16] : mm_data[15:0];

  assign misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
  assign bad_load  = memRead && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
  assign bad_store = memWrite && (funct3[2] || (funct3[1:0] == 2'b11));
  assign req_fault = (memRead && memWrite) || bad_load || bad_store ||
                     ((memRead || memWrite) && misalign);

  always_comb begin
    merged = mm_data;
    if (funct3[1:0] == 2'b00) begin
      merged[{addr[1:0], 3'b000} +: 8] = writeData[7:0];
    end else begin
      merged[{addr[1], 4'b0000} +: 16] = writeData[15:0];
    end
  end

  always_comb begin
    readData     = 32'h0;
    stall        = 1'b0;
    fault        = 1'b0;
    mm_memRead   = 1'b0;
    mm_memWrite  = 1'b0;
    mm_addr      = 32'h0;
    mm_writeData = 32'h0;
    state_d      = state_q;
    merge_d      = merge_q;
    waddr_d      = waddr_q;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (req_fault) begin
            fault = 1'b1;
          end else if (memRead) begin
            mm_memRead = 1'b1;
            mm_addr    = {{PadBits{1'b0}}, word_idx};
            case (funct3)
              3'b000:  readData = {{24{ld_byte[7]}}, ld_byte};
              3'b001:  readData = {{16{ld_half[15]}}, ld_half};
              3'b010:  readData = mm_data;
              3'b100:  readData = {24'h0, ld_byte};
              3'b101:  readData = {16'h0, ld_half};
              default: readData = 32'h0;
            endcase
          end else if (memWrite) begin
            mm_addr = {{PadBits{1'b0}}, word_idx};
            if (funct3 == 3'b010) begin
              mm_memWrite  = 1'b1;
              mm_writeData = writeData;
            end else begin
              // Read phase of the RMW: capture merged word, write it next cycle.
              mm_memRead = 1'b1;
              stall      = 1'b1;
              merge_d    = merged;
              waddr_d    = word_idx;
              state_d    = StRmwWr;
            end
          end
        end
        StRmwWr: begin
          mm_memWrite  = 1'b1;
          mm_addr      = {{PadBits{1'b0}}, waddr_q};
          mm_writeData = merge_q;
          state_d      = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      merge_q <= 32'h0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory
// (combinational read, write on posedge).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        fault;
  logic        mm_memRead;
  logic        mm_memWrite;
  logic [31:0] mm_addr;
  logic [31:0] mm_writeData;
  logic [31:0] mm_data;

  logic [31:0] mem [1024];
  int          n_checks;
  int          n_bad;

  load_store_unit #(.WORD_ADDR_BITS(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .funct3       (funct3),
    .addr         (addr),
    .writeData    (writeData),
    .readData     (readData),
    .stall        (stall),
    .fault        (fault),
    .mm_memRead   (mm_memRead),
    .mm_memWrite  (mm_memWrite),
    .mm_addr      (mm_addr),
    .mm_writeData (mm_writeData),
    .mm_data      (mm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mm_data = mem[mm_addr[9:0]];

  always @(posedge clk) begin
    if (mm_memWrite) mem[mm_addr[9:0]] <= mm_writeData;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply a request just after a falling edge, then let outputs settle.
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    memRead   = rd;
    memWrite  = wr;
    funct3    = f3;
    addr      = a;
    writeData = wd;
    #1;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1]    = 32'h8899AABB;
    rst       = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h4;
    writeData = 32'h0;
    #12;
    check_eq("rst_readData", readData, 32'h0);
    check_eq("rst_mm_memRead", {31'h0, mm_memRead}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_mm_addr", mm_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    check_eq("idle_readData", readData, 32'h0);
    check_eq("idle_strobes", {30'h0, mm_memRead, mm_memWrite}, 32'h0);

    // Loads
    req(1'b1, 1'b0, 3'b000, 32'h5, 32'h0);
    check_eq("lb_5", readData, 32'hFFFFFFAA);
    check_eq("lb_5_stall", {31'h0, stall}, 32'h0);
    req(1'b1, 1'b0, 3'b100, 32'h5, 32'h0);
    check_eq("lbu_5", readData, 32'h000000AA);
    req(1'b1, 1'b0, 3'b001, 32'h6, 32'h0);
    check_eq("lh_6", readData, 32'hFFFF8899);
    req(1'b1, 1'b0, 3'b101, 32'h4, 32'h0);
    check_eq("lhu_4", readData, 32'h0000AABB);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    check_eq("lw_4", readData, 32'h8899AABB);
    check_eq("lw_4_mm_addr", mm_addr, 32'h1);
    check_eq("lw_4_mm_memRead", {31'h0, mm_memRead}, 32'h1);
    req(1'b1, 1'b0, 3'b010, 32'h1004, 32'h0);
    check_eq("lw_wrap_addr", mm_addr, 32'h1);
    check_eq("lw_wrap_data", readData, 32'h8899AABB);
    check_eq("lw_wrap_fault", {31'h0, fault}, 32'h0);

    // SB at byte 2, then SH at low half
    req(1'b0, 1'b1, 3'b000, 32'h6, 32'h12345611);
    check_eq("sb_c1_stall", {31'h0, stall}, 32'h1);
    check_eq("sb_c1_strobes", {30'h0, mm_memRead, mm_memWrite}, 32'h2);
    @(negedge clk);
    #1;
    check_eq("sb_c2_stall", {31'h0, stall}, 32'h0);
    check_eq("sb_c2_strobes", {30'h0, mm_memRead, mm_memWrite}, 32'h1);
    check_eq("sb_c2_wdata", mm_writeData, 32'h8811AABB);
    check_eq("sb_c2_addr", mm_addr, 32'h1);
    idle();
    check_eq("sb_mem", mem[1], 32'h8811AABB);
    req(1'b0, 1'b1, 3'b001, 32'h4, 32'h0000CAFE);
    check_eq("sh_c1_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    #1;
    check_eq("sh_c2_strobes", {30'h0, mm_memRead, mm_memWrite}, 32'h1);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    check_eq("sh_readback", readData, 32'h8811CAFE);

    // Faults
    req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    check_eq("lw_mis_fault", {31'h0, fault}, 32'h1);
    check_eq("lw_mis_mm_memRead", {31'h0, mm_memRead}, 32'h0);
    check_eq("lw_mis_readData", readData, 32'h0);
    req(1'b0, 1'b1, 3'b001, 32'h5, 32'hFFFF);
    check_eq("sh_mis_fault", {31'h0, fault}, 32'h1);
    check_eq("sh_mis_stall", {31'h0, stall}, 32'h0);
    check_eq("sh_mis_strobes", {30'h0, mm_memRead, mm_memWrite}, 32'h0);
    req(1'b1, 1'b0, 3'b011, 32'h4, 32'h0);
    check_eq("ld_f3_011_fault", {31'h0, fault}, 32'h1);
    req(1'b0, 1'b1, 3'b100, 32'h4, 32'h0);
    check_eq("st_f3_100_fault", {31'h0, fault}, 32'h1);
    req(1'b1, 1'b1, 3'b010, 32'h4, 32'h0);
    check_eq("rd_wr_fault", {31'h0, fault}, 32'h1);
    idle();
    check_eq("fault_mem", mem[1], 32'h8811CAFE);

    // Reset during RMW_WR drops the write
    req(1'b0, 1'b1, 3'b000, 32'h4, 32'h00000077);
    check_eq("rstrmw_c1_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rstrmw_stall", {31'h0, stall}, 32'h0);
    check_eq("rstrmw_mm_memWrite", {31'h0, mm_memWrite}, 32'h0);
    @(negedge clk);
    memWrite = 1'b0;
    rst      = 1'b0;
    #1;
    check_eq("rstrmw_mem", mem[1], 32'h8811CAFE);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    check_eq("rstrmw_idle_load", readData, 32'h8811CAFE);
    check_eq("rstrmw_idle_stall", {31'h0, stall}, 32'h0);

    // Back-to-back SB: stall 1,0,1,0 and write strobe 0,1,0,1
    idle();
    mem[1] = 32'h0;
    req(1'b0, 1'b1, 3'b000, 32'h4, 32'h00000001);
    check_eq("b2b_c1", {30'h0, stall, mm_memWrite}, 32'h2);
    @(negedge clk);
    #1;
    check_eq("b2b_c2", {30'h0, stall, mm_memWrite}, 32'h1);
    req(1'b0, 1'b1, 3'b000, 32'h5, 32'h00000002);
    check_eq("b2b_c3", {30'h0, stall, mm_memWrite}, 32'h2);
    @(negedge clk);
    #1;
    check_eq("b2b_c4", {30'h0, stall, mm_memWrite}, 32'h1);
    check_eq("b2b_c4_wdata", mm_writeData, 32'h00000201);
    idle();
    check_eq("b2b_mem", mem[1], 32'h00000201);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
